// File: rtl/weighted_rr_arbiter_pkg.sv
// Shared constants and elaboration-time helpers for the weighted round-robin arbiter.
package weighted_rr_arbiter_pkg;

  localparam int WRR_MAX_REQUESTERS = 32;

  // Cyclic span mask: bits start, start+1, ... up to (but excluding) stop, wrapping at n.
  // Empty when start == stop.
  function automatic logic [WRR_MAX_REQUESTERS-1:0] wrap_span_mask(input int start,
                                                                  input int stop,
                                                                  input int n);
    logic [WRR_MAX_REQUESTERS-1:0] mask;
    logic                          hit;
    int                            pos;
    mask = '0;
    hit  = 1'b0;
    for (int k = 0; k < n; k++) begin
      pos = (start + k) % n;
      if (pos == stop) hit = 1'b1;
      if (!hit) mask[pos] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/weighted_rr_arbiter_oh_to_idx.sv
// One-hot to binary index encoder; an all-zero input encodes to index 0.
module weighted_rr_arbiter_oh_to_idx #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] oh,
  output logic [W-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | W'(i);
    end
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter with a zero-latency combinational grant,
// per-requester credit counters and a grant lock for multi-beat transactions.
module weighted_rr_arbiter
  import weighted_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int WEIGHT_WIDTH   = 4,
  parameter int IDX_WIDTH      = $clog2(NUM_REQUESTERS)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQUESTERS-1:0]              request,
  input  logic [NUM_REQUESTERS*WEIGHT_WIDTH-1:0] weight,
  input  logic                                   update_lru,
  input  logic                                   grant_lock,
  output logic [NUM_REQUESTERS-1:0]              grant_oh,
  output logic [IDX_WIDTH-1:0]                   grant_idx,
  output logic                                   locked
);

  logic [NUM_REQUESTERS-1:0] priority_oh_q, priority_oh_d;
  logic [NUM_REQUESTERS-1:0] locked_oh_q, locked_oh_d;
  logic [NUM_REQUESTERS-1:0][WEIGHT_WIDTH-1:0] credit_q, credit_d, credit_used;
  logic [NUM_REQUESTERS-1:0] rr_grant;
  logic [NUM_REQUESTERS-1:0] last_credit;
  logic [NUM_REQUESTERS-1:0] grant_rot;
  logic                      lock_hit;
  logic                      fire;

  // Requester i wins unless some requester between the priority pointer and i asks first.
  for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_search
    logic [NUM_REQUESTERS-1:0] blocked;
    for (genvar p = 0; p < NUM_REQUESTERS; p++) begin : g_start
      localparam logic [WRR_MAX_REQUESTERS-1:0] SPAN = wrap_span_mask(p, i, NUM_REQUESTERS);
      assign blocked[p] = |(request & SPAN[NUM_REQUESTERS-1:0]);
    end
    assign rr_grant[i] = request[i] & ~|(priority_oh_q & blocked);
  end

  assign lock_hit  = |(locked_oh_q & request);
  assign grant_oh  = lock_hit ? locked_oh_q : rr_grant;
  assign fire      = update_lru & (|grant_oh);
  assign grant_rot = {grant_oh[NUM_REQUESTERS-2:0], grant_oh[NUM_REQUESTERS-1]};
  assign locked    = |locked_oh_q;

  // A stored credit of zero means the quota is exhausted and reloads from the weight on next use.
  for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_credit
    logic [WEIGHT_WIDTH-1:0] ew;
    logic [WEIGHT_WIDTH-1:0] cur;
    assign ew             = (weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0) ?
                            WEIGHT_WIDTH'(1) : weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign cur            = (credit_q[i] == '0) ? ew : credit_q[i];
    assign last_credit[i] = (cur == WEIGHT_WIDTH'(1));
    assign credit_used[i] = last_credit[i] ? '0 : cur - WEIGHT_WIDTH'(1);
  end

  always_comb begin
    priority_oh_d = priority_oh_q;
    locked_oh_d   = locked_oh_q;
    credit_d      = credit_q;
    if (fire) begin
      if (grant_lock) begin
        locked_oh_d = grant_oh;
      end else begin
        locked_oh_d   = '0;
        priority_oh_d = (|(grant_oh & last_credit)) ? grant_rot : grant_oh;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
          if (grant_oh[i]) credit_d[i] = credit_used[i];
        end
      end
    end else if (!lock_hit) begin
      locked_oh_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      priority_oh_q <= {{(NUM_REQUESTERS-1){1'b0}}, 1'b1};
      locked_oh_q   <= '0;
      credit_q      <= '0;
    end else begin
      priority_oh_q <= priority_oh_d;
      locked_oh_q   <= locked_oh_d;
      credit_q      <= credit_d;
    end
  end

  weighted_rr_arbiter_oh_to_idx #(
    .N(NUM_REQUESTERS),
    .W(IDX_WIDTH)
  ) u_oh_to_idx (
    .oh (grant_oh),
    .idx(grant_idx)
  );

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!reset) $onehot0(grant_oh));
  a_priority_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot(priority_oh_q));
  a_update_has_request: assert property (@(posedge clk) disable iff (!reset)
                                         update_lru |-> (request != '0));

endmodule
